// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and constants for the two-source round-robin mux arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} arb_state_t;

  localparam logic SRC_A = 1'b1;
  localparam logic SRC_B = 1'b0;

  localparam int DEF_MAX_BURST = 1;

endpackage

// File: rtl/mux2to1.sv
// Plain 2:1 data mux: selector 1 passes in_a, 0 passes in_b.
module mux2to1 #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_selector,
  output logic [DW-1:0] o_out
);

  assign o_out = in_selector ? in_a : in_b;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin (burst-limited) arbiter sharing one 2:1 mux between two valid/ready
// sources, with a one-entry registered output stage and saturating transfer counters.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int DW        = 4,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CNT_W     = 16
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_a_valid,
  input  logic [DW-1:0]    in_a,
  output logic             o_a_ready,
  input  logic             in_b_valid,
  input  logic [DW-1:0]    in_b,
  output logic             o_b_ready,
  output logic             o_valid,
  output logic [DW-1:0]    o_result,
  output logic             o_src,
  input  logic             in_ready,
  output logic [CNT_W-1:0] o_cnt_a,
  output logic [CNT_W-1:0] o_cnt_b
);

  arb_state_t    state;
  logic          last_grant;
  logic [3:0]    burst_cnt;
  logic          accept;
  logic          grant_vld;
  logic          grant;
  logic          xfer;
  logic [DW-1:0] mux_out;

  assign o_valid = (state != IDLE);
  assign o_src   = (state == SERVE_A);
  assign accept  = !o_valid || in_ready;

  // burst_cnt==0 only right after reset: no run in progress, so hand the
  // first contested grant to the source opposite last_grant (A).
  always_comb begin
    grant_vld = in_a_valid || in_b_valid;
    grant     = SRC_B;
    if (in_a_valid && in_b_valid) begin
      if (burst_cnt != 4'd0 && burst_cnt < 4'(MAX_BURST)) grant = last_grant;
      else                                               grant = !last_grant;
    end else if (in_a_valid) begin
      grant = SRC_A;
    end
  end

  assign o_a_ready = in_rst_n && accept && grant_vld && (grant == SRC_A);
  assign o_b_ready = in_rst_n && accept && grant_vld && (grant == SRC_B);
  assign xfer      = (o_a_ready && in_a_valid) || (o_b_ready && in_b_valid);

  mux2to1 #(.DW(DW)) u_mux (
    .in_a        (in_a),
    .in_b        (in_b),
    .in_selector (grant),
    .o_out       (mux_out)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state      <= IDLE;
      o_result   <= '0;
      o_cnt_a    <= '0;
      o_cnt_b    <= '0;
      last_grant <= SRC_B;
      burst_cnt  <= 4'd0;
    end else if (accept) begin
      if (xfer) begin
        state      <= (grant == SRC_A) ? SERVE_A : SERVE_B;
        o_result   <= mux_out;
        last_grant <= grant;
        if (grant != last_grant)             burst_cnt <= 4'd1;
        else if (burst_cnt < 4'(MAX_BURST))  burst_cnt <= burst_cnt + 4'd1;
        if (grant == SRC_A) begin
          if (o_cnt_a != {CNT_W{1'b1}}) o_cnt_a <= o_cnt_a + CNT_W'(1);
        end else begin
          if (o_cnt_b != {CNT_W{1'b1}}) o_cnt_b <= o_cnt_b + CNT_W'(1);
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule
